// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative integer divider:
//   - div_state_e      : FSM state encoding (IDLE / CALC / DONE)
//   - DIV_DIVZERO_QUOT : all-ones quotient pattern returned on divide by zero
//   - abs_val()        : two's-complement magnitude of a WIDTH-bit value
// No ports (package).
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_MAX_W = 64;

  // Callers truncate this to their own WIDTH.
  localparam logic [DIV_MAX_W-1:0] DIV_DIVZERO_QUOT = {DIV_MAX_W{1'b1}};

  // Magnitude of the low 'width' bits of val, treating bit width-1 as the sign.
  // The most negative value maps to itself, which reads correctly as unsigned.
  function automatic logic [63:0] abs_val(input logic [63:0] val, input int width);
    logic [63:0] mask;
    logic [63:0] neg;
    logic        sign_bit;
    if (width >= 32'sd64) begin
      mask = {64{1'b1}};
    end else begin
      mask = (64'd1 << width) - 64'd1;
    end
    sign_bit = |(val & (64'd1 << (width - 32'sd1)));
    neg      = (~val + 64'd1) & mask;
    if (sign_bit) begin
      abs_val = neg;
    end else begin
      abs_val = val & mask;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_i      [WIDTH:0]   partial remainder before this step
//   dvd_bit_i  1           next dividend bit (MSB first)
//   divisor_i  [WIDTH-1:0] divisor magnitude
//   rem_o      [WIDTH:0]   partial remainder after this step
//   quot_bit_o 1           quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             quot_bit_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;
  logic           fits_s;

  // Shift-left, trial subtract, keep or restore.
  always_comb begin
    // The true shifted value is WIDTH+2 bits; its top bit is rem_i[WIDTH].
    // When that bit is set the divisor always fits, and the wrapped
    // WIDTH+1-bit difference is still exact because the result is < divisor.
    shifted_s = {rem_i[WIDTH-1:0], dvd_bit_i};
    trial_s   = shifted_s - {1'b0, divisor_i};
    fits_s    = rem_i[WIDTH] | (shifted_s >= {1'b0, divisor_i});
    if (fits_s) begin
      rem_o      = trial_s;
      quot_bit_o = 1'b1;
    end else begin
      rem_o      = shifted_s;
      quot_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
// Multi-cycle radix-2 restoring divider (div.w / div.wu / mod.w / mod.wu).
// Produces quotient and remainder together; valid/ready on request and result.
// Ports:
//   clk, resetn (sync, active low)
//   div_valid/div_ready             request handshake
//   div_signed, div_src1, div_src2  operation and operands (src1 / src2)
//   div_cancel                      flush any in-flight or completed operation
//   res_valid/res_ready             result handshake
//   div_quot, div_rem               registered results (valid with res_valid)
//   div_busy                        unit not idle
// -----------------------------------------------------------------------------
module div_iter_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem,
  output logic             div_busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_W1  = {(WIDTH+1){1'b0}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             accept_s;
  logic             div_zero_s;
  logic [WIDTH-1:0] opa_s, opb_s;
  logic [WIDTH:0]   step_rem_s;
  logic             step_qbit_s;
  logic [WIDTH-1:0] q_raw_s, r_raw_s;
  logic [WIDTH-1:0] q_fix_s, r_fix_s;

  assign accept_s   = (state_q == IDLE) & div_valid & ~div_cancel;
  assign div_zero_s = (div_src2 == ZERO_W);
  assign opa_s      = div_signed ? WIDTH'(abs_val(64'(div_src1), WIDTH)) : div_src1;
  assign opb_s      = div_signed ? WIDTH'(abs_val(64'(div_src2), WIDTH)) : div_src2;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i      (prem_q),
    .dvd_bit_i  (dvd_q[WIDTH-1]),
    .divisor_i  (dsr_q),
    .rem_o      (step_rem_s),
    .quot_bit_o (step_qbit_s)
  );

  // Final-step raw results and their sign fixup (folded into the CALC->DONE edge).
  always_comb begin
    q_raw_s = {dvd_q[WIDTH-2:0], step_qbit_s};
    r_raw_s = step_rem_s[WIDTH-1:0];
    if (quot_neg_q) begin
      q_fix_s = ~q_raw_s + ONE_W;
    end else begin
      q_fix_s = q_raw_s;
    end
    if (rem_neg_q) begin
      r_fix_s = ~r_raw_s + ONE_W;
    end else begin
      r_fix_s = r_raw_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; cancel overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else if (div_valid) begin
          state_d = div_zero_s ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (div_cancel || res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    div_ready = 1'b0;
    res_valid = 1'b0;
    div_busy  = 1'b1;
    case (state_q)
      IDLE: begin
        div_ready = 1'b1;
        div_busy  = 1'b0;
      end
      CALC: begin
        div_busy = 1'b1;
      end
      DONE: begin
        res_valid = 1'b1;
      end
      default: begin
        div_ready = 1'b0;
        res_valid = 1'b0;
        div_busy  = 1'b1;
      end
    endcase
  end

  // Datapath next-state: load on accept, iterate in CALC, publish on the last step.
  always_comb begin
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    prem_d     = prem_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    if (accept_s) begin
      cnt_d      = CNT_LAST;
      dvd_d      = opa_s;
      dsr_d      = opb_s;
      prem_d     = ZERO_W1;
      quot_neg_d = div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
      rem_neg_d  = div_signed & div_src1[WIDTH-1];
      if (div_zero_s) begin
        // Raw dividend, not its magnitude, in both modes.
        quot_d = WIDTH'(DIV_DIVZERO_QUOT);
        rem_d  = div_src1;
      end else begin
        quot_d = quot_q;
        rem_d  = rem_q;
      end
    end else if ((state_q == CALC) && !div_cancel) begin
      dvd_d  = q_raw_s;
      prem_d = step_rem_s;
      if (cnt_q == CNT_ZERO) begin
        quot_d = q_fix_s;
        rem_d  = r_fix_s;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q      <= CNT_ZERO;
      dvd_q      <= ZERO_W;
      dsr_q      <= ZERO_W;
      prem_q     <= ZERO_W1;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      quot_q     <= ZERO_W;
      rem_q      <= ZERO_W;
    end else begin
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      prem_q     <= prem_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

  assign div_quot = quot_q;
  assign div_rem  = rem_q;

endmodule
